time_set_ctrl: RTL

- Time-setting front end of the digital clock; sits directly upstream of the hour/minute/second modulo counters.
- Debounces two raw push-buttons (MODE, INC) and runs a RUN / SET_HOUR / SET_MIN state machine.
- Gates the counting chain enable and drives the counters' synchronous load/digit inputs.
- Provides blink controls for the display stage.

---
 rtl/time_set_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// Time-setting front end: debounces MODE/INC, runs RUN/SET_HOUR/SET_MIN, drives counter loads and blink.
// Optional INC auto-repeat is built when TIME_SET_AUTO_REPEAT_EN is defined.
module time_set_ctrl #(
    parameter int HOUR_MOD        = 24,
    parameter int MIN_MOD         = 60,
    parameter int HOUR_W          = 6,
    parameter int MIN_W           = 7,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int BLINK_CYCLES    = 500,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [HOUR_W-1:0] hours_in,
    input  logic [MIN_W-1:0]  min_in,
    output logic              run_en,
    output logic              hours_load,
    output logic [HOUR_W-1:0] hours_digit,
    output logic              min_load,
    output logic [MIN_W-1:0]  min_digit,
    output logic              sec_load,
    output logic [MIN_W-1:0]  sec_digit,
    output logic              blank_hours,
    output logic              blank_min,
    output logic [1:0]        mode_state
);

    typedef enum logic [1:0] {RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10} state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BL_W = $clog2(BLINK_CYCLES + 1);

    // Index 0 is MODE, index 1 is INC.
    logic [1:0]      sync1_q, sync2_q, deb_q, pulse_q;
    logic [DB_W-1:0] db_cnt_q [2];

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            pulse_q <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= {btn_inc, btn_mode};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                pulse_q[i] <= 1'b0;
                if (sync2_q[i] == deb_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt_q[i] <= '0;
                    deb_q[i]    <= sync2_q[i];
                    pulse_q[i]  <= sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    state_t            state_q, state_d;
    logic [HOUR_W-1:0] hour_edit_q, hour_edit_d, hours_digit_q, hours_digit_d;
    logic [MIN_W-1:0]  min_edit_q, min_edit_d, min_digit_q, min_digit_d;
    logic              load_q, load_d;
    logic [BL_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;
    logic              mode_p, inc_p, rep_p;

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int RP_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    logic [RP_W-1:0] hold_cnt_q;
    logic            repeating_q, rep_p_q;

    // First repeat after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            hold_cnt_q  <= '0;
            repeating_q <= 1'b0;
            rep_p_q     <= 1'b0;
        end else begin
            rep_p_q <= 1'b0;
            if (!deb_q[1] || state_q == RUN || state_d != state_q) begin
                hold_cnt_q  <= '0;
                repeating_q <= 1'b0;
            end else if (hold_cnt_q == (repeating_q ? RP_W'(REPEAT_PERIOD - 1)
                                                    : RP_W'(REPEAT_DELAY - 1))) begin
                hold_cnt_q  <= '0;
                repeating_q <= 1'b1;
                rep_p_q     <= 1'b1;
            end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
        end
    end
    assign rep_p = rep_p_q;
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
    assign rep_p = 1'b0;
`endif

    assign mode_p = pulse_q[0];
    assign inc_p  = pulse_q[1] | rep_p;

    always_comb begin
        state_d       = state_q;
        hour_edit_d   = hour_edit_q;
        min_edit_d    = min_edit_q;
        load_d        = 1'b0;
        hours_digit_d = '0;
        min_digit_d   = '0;
        case (state_q)
            RUN: begin
                if (mode_p) begin
                    state_d     = SET_HOUR;
                    hour_edit_d = (32'(hours_in) >= 32'(HOUR_MOD)) ? '0 : hours_in;
                    min_edit_d  = (32'(min_in) >= 32'(MIN_MOD)) ? '0 : min_in;
                end
            end
            SET_HOUR: begin
                if (mode_p) begin
                    state_d = SET_MIN;
                end else if (inc_p) begin
                    hour_edit_d = (hour_edit_q == HOUR_W'(HOUR_MOD - 1)) ? '0 : hour_edit_q + 1'b1;
                end
            end
            SET_MIN: begin
                if (mode_p) begin
                    state_d       = RUN;
                    load_d        = 1'b1;
                    hours_digit_d = hour_edit_q;
                    min_digit_d   = min_edit_q;
                end else if (inc_p) begin
                    min_edit_d = (min_edit_q == MIN_W'(MIN_MOD - 1)) ? '0 : min_edit_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        // Blink restarts visible on every state change.
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (state_d == state_q && (state_q == SET_HOUR || state_q == SET_MIN)) begin
            if (blink_cnt_q == BL_W'(BLINK_CYCLES - 1)) begin
                phase_d = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                phase_d     = phase_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q       <= RUN;
            hour_edit_q   <= '0;
            min_edit_q    <= '0;
            load_q        <= 1'b0;
            hours_digit_q <= '0;
            min_digit_q   <= '0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hour_edit_q   <= hour_edit_d;
            min_edit_q    <= min_edit_d;
            load_q        <= load_d;
            hours_digit_q <= hours_digit_d;
            min_digit_q   <= min_digit_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
        end
    end

    assign run_en      = (state_q == RUN);
    assign hours_load  = load_q;
    assign min_load    = load_q;
    assign sec_load    = load_q;
    assign hours_digit = hours_digit_q;
    assign min_digit   = min_digit_q;
    assign sec_digit   = '0;
    assign blank_hours = (state_q == SET_HOUR) & phase_q;
    assign blank_min   = (state_q == SET_MIN) & phase_q;
    assign mode_state  = state_q;

endmodule
